pool1_out_fifo: RTL and testbench

//  Elastic buffer between the pool1 stage output (blob_dout/en/eop) and the conv2 stage input.

---
 rtl/pool1_out_fifo.sv | 125 ++++++++++++
 tb/tb_pool1_out_fifo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool1_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pool1_out_fifo
// Purpose  : Elastic buffer between the pool1 output stream and the conv2
//            input. Absorbs words still in flight after backpressure is
//            raised, re-times the stream onto a registered rdy/en/eop
//            handshake, and checks blob framing (length and eop position).
// Revision : 1.0 - initial release
// ============================================================================
module pool1_out_fifo #(
   parameter int DW        = 16,
   parameter int DEPTH     = 32,
   parameter int AW        = 5,
   parameter int SLACK     = 8,
   parameter int FRAME_LEN = 8192,
   parameter int CNT_W     = 14
) (
   input  logic          clk,
   input  logic          rst,
   output logic          blob_din_rdy,
   input  logic          blob_din_en,
   input  logic          blob_din_eop,
   input  logic [DW-1:0] blob_din,
   input  logic          blob_dout_rdy,
   output logic          blob_dout_en,
   output logic          blob_dout_eop,
   output logic [DW-1:0] blob_dout,
   output logic          ovf_err,
   output logic          frame_err
);

   localparam logic [AW:0]      FULL_CNT   = (AW+1)'(DEPTH);
   localparam logic [AW:0]      RDY_THRESH = (AW+1)'(DEPTH - SLACK);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);

   // Storage: each entry carries its eop flag in the MSB.
   logic [DW:0]      mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_next;
   logic [CNT_W-1:0] fcnt;

   logic full;
   logic empty;
   logic wr_ok;
   logic pop;

   // Full/empty decisions use the pre-edge count, so a pop never frees a
   // slot for a write in the same cycle.
   always_comb begin
      full       = (count == FULL_CNT);
      empty      = (count == '0);
      wr_ok      = blob_din_en && !full;
      pop        = blob_dout_rdy && !empty;
      count_next = count;
      case ({wr_ok, pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   // Array write; contents are don't-care after reset since pointers clear.
   always_ff @(posedge clk) begin
      if (rst && wr_ok) begin
         mem[wr_ptr] <= {blob_din_eop, blob_din};
      end
   end

   // Pointers, occupancy, registered output port and backpressure.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         blob_din_rdy  <= 1'b0;
         blob_dout_en  <= 1'b0;
         blob_dout_eop <= 1'b0;
         blob_dout     <= '0;
         ovf_err       <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr        <= rd_ptr + 1'b1;
            blob_dout_en  <= 1'b1;
            blob_dout_eop <= mem[rd_ptr][DW];
            blob_dout     <= mem[rd_ptr][DW-1:0];
         end else begin
            blob_dout_en  <= 1'b0;
            blob_dout_eop <= 1'b0;
         end
         count        <= count_next;
         // Dropping rdy while SLACK entries remain covers upstream latency.
         blob_din_rdy <= (count_next <= RDY_THRESH);
         if (blob_din_en && full) begin
            ovf_err <= 1'b1;
         end
      end
   end

   // Frame length check: every offered word counts, even dropped ones.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fcnt      <= '0;
         frame_err <= 1'b0;
      end else if (blob_din_en) begin
         if (blob_din_eop) begin
            if (fcnt != FRAME_LAST) begin
               frame_err <= 1'b1;
            end
            fcnt <= '0;
         end else if (fcnt == FRAME_LAST) begin
            frame_err <= 1'b1;
            fcnt      <= '0;
         end else begin
            fcnt <= fcnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pool1_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool1_out_fifo
// Purpose  : Self-checking bench for pool1_out_fifo: hand-computed vector
//            table, directed corner sequences and a randomized run, all
//            compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pool1_out_fifo;
   localparam int DW        = 16;
   localparam int DEPTH     = 32;
   localparam int SLACK     = 8;
   localparam int FRAME_LEN = 8192;

   logic          clk = 1'b0;
   logic          rst;
   logic          din_en;
   logic          din_eop;
   logic [DW-1:0] din;
   logic          dout_rdy;
   logic          din_rdy;
   logic          dout_en;
   logic          dout_eop;
   logic [DW-1:0] dout;
   logic          ovf;
   logic          ferr;

   always #5 clk = ~clk;

   pool1_out_fifo dut (
      .clk           (clk),
      .rst           (rst),
      .blob_din_rdy  (din_rdy),
      .blob_din_en   (din_en),
      .blob_din_eop  (din_eop),
      .blob_din      (din),
      .blob_dout_rdy (dout_rdy),
      .blob_dout_en  (dout_en),
      .blob_dout_eop (dout_eop),
      .blob_dout     (dout),
      .ovf_err       (ovf),
      .frame_err     (ferr)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state: a plain queue of {eop,data} plus expected outputs.
   logic [DW:0]   mq[$];
   logic          m_en, m_eop, m_rdyin, m_ovf, m_ferr;
   logic [DW-1:0] m_dout;
   int            m_words;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endfunction

   // One clock: drive at negedge, advance the model at posedge, compare #1 later.
   task automatic step(input bit r, input bit en, input bit eop, input logic [DW-1:0] d, input bit rdy);
      logic [DW:0] e;
      bit          do_pop;
      bit          was_full;
      @(negedge clk);
      rst = r; din_en = en; din_eop = eop; din = d; dout_rdy = rdy;
      @(posedge clk);
      if (!r) begin
         mq.delete();
         m_en = 0; m_eop = 0; m_dout = '0; m_rdyin = 0; m_ovf = 0; m_ferr = 0; m_words = 0;
      end else begin
         do_pop   = rdy && (mq.size() != 0);
         was_full = (mq.size() == DEPTH);
         e        = '0;
         if (do_pop) e = mq.pop_front();
         if (en) begin
            if (!was_full) mq.push_back({eop, d});
            else m_ovf = 1;
            if (eop) begin
               if (m_words != FRAME_LEN - 1) m_ferr = 1;
               m_words = 0;
            end else if (m_words == FRAME_LEN - 1) begin
               m_ferr  = 1;
               m_words = 0;
            end else begin
               m_words++;
            end
         end
         if (do_pop) begin
            m_en = 1; m_eop = e[DW]; m_dout = e[DW-1:0];
         end else begin
            m_en = 0; m_eop = 0;
         end
         m_rdyin = (mq.size() <= DEPTH - SLACK);
      end
      #1;
      chk("din_rdy",   din_rdy,  m_rdyin);
      chk("dout_en",   dout_en,  m_en);
      chk("dout_eop",  dout_eop, m_eop);
      chk("dout",      dout,     m_dout);
      chk("ovf_err",   ovf,      m_ovf);
      chk("frame_err", ferr,     m_ferr);
   endtask

   task automatic do_reset(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         step(0, 0, 0, '0, 0);
         chk("rst_outputs", {din_rdy, dout_en, dout_eop, ovf, ferr, dout}, '0);
      end
      step(1, 0, 0, '0, 0);
      chk("rdy_after_release", din_rdy, 1);
      chk("en_after_release", dout_en, 0);
   endtask

   typedef struct {
      bit            en;
      logic [DW-1:0] d;
      bit            rdy;
      bit            x_en;
      logic [DW-1:0] x_dout;
      bit            x_rdyin;
   } vec_t;

   initial begin
      vec_t tbl[6];
      int   out_idx;
      int   n_out;
      bit   bad;

      rst = 0; din_en = 0; din_eop = 0; din = '0; dout_rdy = 0;

      // Hand-derived vectors from an empty FIFO.
      tbl[0] = '{1, 16'h1111, 1, 0, 16'h0000, 1};
      tbl[1] = '{1, 16'h2222, 1, 1, 16'h1111, 1};
      tbl[2] = '{0, 16'h0000, 0, 0, 16'h1111, 1};
      tbl[3] = '{0, 16'h0000, 0, 0, 16'h1111, 1};
      tbl[4] = '{0, 16'h0000, 1, 1, 16'h2222, 1};
      tbl[5] = '{0, 16'h0000, 1, 0, 16'h2222, 1};

      // Reset held 3 cycles then released.
      do_reset(3);
      step(1, 0, 0, '0, 1);
      chk("idle_en", dout_en, 0);

      for (int i = 0; i < 6; i++) begin
         step(1, tbl[i].en, 0, tbl[i].d, tbl[i].rdy);
         chk("tbl_dout_en", dout_en, tbl[i].x_en);
         chk("tbl_dout", dout, tbl[i].x_dout);
         chk("tbl_din_rdy", din_rdy, tbl[i].x_rdyin);
      end

      // Full clean blob streamed straight through.
      do_reset(2);
      out_idx = 0;
      bad = 0;
      for (int i = 0; i < FRAME_LEN + 2; i++) begin
         if (i < FRAME_LEN) step(1, 1, i == FRAME_LEN - 1, DW'(i), 1);
         else step(1, 0, 0, '0, 1);
         if (i == 0) chk("t2_no_out_yet", dout_en, 0);
         if (i == 1) chk("t2_first_out", {dout_en, dout}, {1'b1, 16'h0000});
         if (dout_en) begin
            if (dout != DW'(out_idx) || dout_eop != (out_idx == FRAME_LEN - 1)) bad = 1;
            out_idx++;
         end
      end
      chk("t2_order_eop", bad, 0);
      chk("t2_words_out", out_idx, FRAME_LEN);
      chk("t2_frame_err", ferr, 0);

      // Backpressure threshold and overflow with output stalled.
      do_reset(2);
      for (int i = 0; i < 24; i++) step(1, 1, 0, DW'(i), 0);
      chk("t3_rdy_at_24", din_rdy, 1);
      step(1, 1, 0, DW'(24), 0);
      chk("t3_rdy_at_25", din_rdy, 0);
      for (int i = 25; i < 32; i++) step(1, 1, 0, DW'(i), 0);
      chk("t3_ovf_at_32", ovf, 0);
      step(1, 1, 0, DW'(32), 0);
      chk("t3_ovf_at_33", ovf, 1);
      n_out = 0;
      bad = 0;
      for (int i = 0; i < 36; i++) begin
         step(1, 0, 0, '0, 1);
         if (dout_en) begin
            if (dout != DW'(n_out)) bad = 1;
            n_out++;
         end
      end
      chk("t3_drain_order", bad, 0);
      chk("t3_drain_count", n_out, 32);

      // Write+pop at full: write dropped, 31 remain.
      do_reset(2);
      for (int i = 0; i < 32; i++) step(1, 1, 0, DW'(100 + i), 0);
      step(1, 1, 0, 16'hBEEF, 1);
      chk("t4_ovf", ovf, 1);
      chk("t4_pop_word", {dout_en, dout}, {1'b1, 16'd100});
      n_out = 0;
      bad = 0;
      for (int i = 0; i < 36; i++) begin
         step(1, 0, 0, '0, 1);
         if (dout_en) begin
            if (dout == 16'hBEEF) bad = 1;
            n_out++;
         end
      end
      chk("t4_remaining_31", n_out, 31);
      chk("t4_dropped_absent", bad, 0);

      // Write+pop at count 5 keeps occupancy.
      do_reset(2);
      for (int i = 0; i < 5; i++) step(1, 1, 0, DW'(i), 0);
      step(1, 1, 0, 16'h0055, 1);
      n_out = 0;
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 0, '0, 1);
         if (dout_en) n_out++;
      end
      chk("t4_count5_kept", n_out, 5);
      chk("t4_last_word", dout, 16'h0055);

      // Early eop.
      do_reset(2);
      for (int i = 0; i < 101; i++) begin
         step(1, 1, i == 100, DW'(i), 1);
         if (i == 99) chk("t5_no_err_before", ferr, 0);
      end
      chk("t5_early_eop", ferr, 1);

      // Missing eop.
      do_reset(2);
      for (int i = 0; i < FRAME_LEN; i++) begin
         step(1, 1, 0, DW'(i), 1);
         if (i == FRAME_LEN - 2) chk("t5_no_err_at_8190", ferr, 0);
      end
      chk("t5_missing_eop", ferr, 1);

      // Reset with words buffered mid-frame and both flags set.
      do_reset(2);
      for (int i = 0; i < 40; i++) step(1, 1, i == 3, DW'(i), 0);
      for (int i = 0; i < 22; i++) step(1, 0, 0, '0, 1);
      chk("t6_flags_set", {ovf, ferr}, 2'b11);
      do_reset(2);
      step(1, 0, 0, '0, 1);
      step(1, 0, 0, '0, 1);
      chk("t6_empty_after_rst", dout_en, 0);
      out_idx = 0;
      for (int i = 0; i < FRAME_LEN + 2; i++) begin
         if (i < FRAME_LEN) step(1, 1, i == FRAME_LEN - 1, DW'(i), 1);
         else step(1, 0, 0, '0, 1);
         if (dout_en) out_idx++;
      end
      chk("t6_clean_words", out_idx, FRAME_LEN);
      chk("t6_clean_frame_err", ferr, 0);

      // Randomized traffic checked cycle by cycle against the model.
      do_reset(2);
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 999) != 0,
              $urandom_range(0, 9) < 7,
              $urandom_range(0, 499) == 0,
              DW'($urandom),
              $urandom_range(0, 1) == 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
